// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, R-type funct codes, mul/div FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_decode.sv
// Classifies R-type functs that belong to the HI/LO multiply/divide unit.
module muldiv_decode
    import mips_pkg::*;
(
    input  logic       en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       md_op,
    output logic       is_mul,
    output logic       is_div,
    output logic       is_signed,
    output logic       is_mf,
    output logic       is_mt,
    output logic       sel_hi
);

    always_comb begin
        md_op     = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mf     = 1'b0;
        is_mt     = 1'b0;
        sel_hi    = 1'b0;
        if (en && opcode == OP_RTYPE) begin
            case (funct)
                MULT: begin
                    md_op = 1'b1; is_mul = 1'b1; is_signed = 1'b1;
                end
                MULTU: begin
                    md_op = 1'b1; is_mul = 1'b1;
                end
                DIV: begin
                    md_op = 1'b1; is_div = 1'b1; is_signed = 1'b1;
                end
                DIVU: begin
                    md_op = 1'b1; is_div = 1'b1;
                end
                MFHI: begin
                    md_op = 1'b1; is_mf = 1'b1; sel_hi = 1'b1;
                end
                MFLO: begin
                    md_op = 1'b1; is_mf = 1'b1;
                end
                MTHI: begin
                    md_op = 1'b1; is_mt = 1'b1; sel_hi = 1'b1;
                end
                MTLO: begin
                    md_op = 1'b1; is_mt = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO; one result bit per cycle,
// sign handled by operating on magnitudes and negating in the FIX state.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic md_op, is_mul, is_div, is_signed, is_mf, is_mt, sel_hi;

    muldiv_decode u_decode (
        .en        (en),
        .opcode    (opcode),
        .funct     (funct),
        .md_op     (md_op),
        .is_mul    (is_mul),
        .is_div    (is_div),
        .is_signed (is_signed),
        .is_mf     (is_mf),
        .is_mt     (is_mt),
        .sel_hi    (sel_hi)
    );

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               div_op;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               accept;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign busy   = (state != IDLE);
    assign stall  = md_op & busy;
    assign accept = md_op & ~busy;
    assign rdata  = (accept & is_mf) ? (sel_hi ? hi : lo) : '0;

    assign sa    = is_signed & a[WIDTH-1];
    assign sb    = is_signed & b[WIDTH-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;

    assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {msum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;

    assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};

    always_comb begin
        if (trial[WIDTH])
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        if (div_op) begin
            fix_hi = rem;
            fix_lo = dz ? '1 : quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            div_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && (is_mul || is_div)) begin
                        state  <= RUN;
                        cnt    <= CW'(WIDTH - 1);
                        div_op <= is_div;
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa & is_div;
                        dz     <= is_div & (b == '0);
                        if (is_div) begin
                            acc <= {{WIDTH{1'b0}}, abs_a};
                            opb <= abs_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, abs_b};
                            opb <= abs_a;
                        end
                    end else if (accept && is_mt) begin
                        if (sel_hi)
                            hi <= a;
                        else
                            lo <= a;
                    end
                end
                RUN: begin
                    acc <= div_op ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Random and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] rdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] ref_hi;
    logic [W-1:0] ref_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .opcode (opcode),
        .funct  (funct),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .rdata  (rdata),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of MULT/MULTU/DIV/DIVU from plain arithmetic
    task automatic model_md(input logic [5:0] f, input logic [W-1:0] x,
                            input logic [W-1:0] y,
                            output logic [W-1:0] rh,
                            output logic [W-1:0] rl);
        longint      sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (f)
            MULT: begin
                sp = sx * sy;
                up = 64'(sp);
                rh = up[63:32];
                rl = up[31:0];
            end
            MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                rh = up[63:32];
                rl = up[31:0];
            end
            DIV: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    rl = W'(sq);
                    rh = W'(sr);
                end
            end
            DIVU: begin
                if (y == 0) begin
                    rh = x;
                    rl = '1;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        opcode = OP_RTYPE;
        funct  = f;
        a      = x;
        b      = y;
        en     = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one MULT/DIV and follow it to completion
    task automatic run_md(input logic [5:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input string tag);
        int nb;
        int early;
        nb    = 0;
        early = 0;
        issue(f, x, y);
        #1;
        check({tag, "_acc_stall"}, stall, 0);
        step();
        en    = 1'b0;
        funct = F_ADDU;
        while (busy && nb < W + 10) begin
            if (done) early++;
            nb++;
            step();
        end
        model_md(f, x, y, ref_hi, ref_lo);
        check({tag, "_busy_len"}, nb, W + 1);
        check({tag, "_early_done"}, early, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_hi"}, hi, ref_hi);
        check({tag, "_lo"}, lo, ref_lo);
        step();
        check({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        logic [5:0]   fsel [4];
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           ns;
        int           nd;

        fsel[0] = MULT;
        fsel[1] = MULTU;
        fsel[2] = DIV;
        fsel[3] = DIVU;

        reset  = 1'b1;
        en     = 1'b0;
        opcode = OP_RTYPE;
        funct  = F_ADDU;
        a      = '0;
        b      = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b0;

        run_md(MULT, 32'd7, 32'hFFFF_FFFD, "mult_neg");
        check("mult_neg_hi_k", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_k", lo, 32'hFFFF_FFEB);
        run_md(MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        check("multu_hi_k", hi, 32'h1);

        // DIV followed directly by MFLO, which must wait
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        step();
        funct = MFLO;
        #1;
        ns = 0;
        while (stall && ns < W + 10) begin
            ns++;
            step();
        end
        model_md(DIV, 32'hFFFF_FFF9, 32'd2, ref_hi, ref_lo);
        check("mflo_stall_len", ns, W + 1);
        check("mflo_rdata", rdata, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        step();
        en    = 1'b0;
        funct = F_ADDU;

        run_md(DIVU, 32'd100, 32'd0, "divu_z");
        check("divu_z_lo_k", lo, 32'hFFFF_FFFF);
        run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_lo_k", lo, 32'h8000_0000);
        run_md(DIV, 32'hFFFF_FFF9, 32'd0, "div_z_neg");

        // MTHI issued mid-DIV stalls and lands after the result
        issue(DIV, 32'd1000, 32'd7);
        step();
        en = 1'b0;
        repeat (3) step();
        opcode = OP_RTYPE;
        funct  = MTHI;
        a      = 32'h1234;
        en     = 1'b1;
        #1;
        check("mthi_stalled", stall, 1);
        ns = 0;
        while (stall && ns < W + 10) begin
            ns++;
            step();
        end
        model_md(DIV, 32'd1000, 32'd7, ref_hi, ref_lo);
        check("mthi_wait_done", done, 1);
        check("mthi_hi_div", hi, ref_hi);
        step();
        en    = 1'b0;
        funct = F_ADDU;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, ref_lo);

        // Non-md instruction while busy
        issue(MULT, 32'd9, 32'd11);
        step();
        funct = F_ADDU;
        #1;
        check("addu_no_stall", stall, 0);
        check("addu_busy", busy, 1);
        en = 1'b0;
        ns = 0;
        while (busy && ns < W + 10) begin
            ns++;
            step();
        end
        check("addu_mult_lo", lo, 32'd99);

        // Reset in the middle of a MULT
        issue(MULT, 32'd12345, 32'd678);
        step();
        en = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (W + 5) begin
            step();
            if (done) nd++;
        end
        check("mid_rst_no_done", nd, 0);
        run_md(MULT, 32'd3, 32'd5, "mult_3x5");
        check("mult_3x5_lo_k", lo, 32'd15);

        // Randomized MULT/DIV mix, with MTLO/MFHI/MFLO in between
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = '1; end
                2: y = $urandom_range(1, 15);
                3: x = -x;
                default: ;
            endcase
            run_md(fsel[$urandom_range(0, 3)], x, y, "rnd");
            issue(MFHI, '0, '0);
            #1;
            check("rnd_mfhi", rdata, ref_hi);
            step();
            funct = MFLO;
            #1;
            check("rnd_mflo", rdata, ref_lo);
            step();
            if (i % 4 == 0) begin
                x     = $urandom;
                funct = MTLO;
                a     = x;
                step();
                ref_lo = x;
                check("rnd_mtlo", lo, ref_lo);
            end
            en = 1'b0;
            #1;
            check("rnd_idle_rdata", rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
